// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard controller. It produces the stall and flush controls for the
// PC, IF/ID and ID/EX registers. It covers load-use hazards, taken
// branch/jump redirects, and multi-cycle mul/div occupancy of EX. It also
// keeps a stall-cycle performance counter.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   IDRs, IDRt          source register fields of the instruction in ID
//   IDUsesRs, IDUsesRt  the ID instruction actually reads rs / rt
//   IDEXMemRead         the EX instruction is a load
//   IDEXRegWrite        the EX instruction writes a register
//   IDEXWriteBackDst    destination register of the EX instruction
//   IDEXMulDiv          the EX instruction is a mul/div
//   EXRedirect          a taken branch/jump in EX redirects the PC
//   PCStall, IFIDStall, IDEXStall   hold controls (combinational)
//   IFIDFlush, IDEXFlush            zero controls (combinational)
//   MdBusy              mul/div state machine is in BUSY
//   StallCycles         number of cycles with PCStall=1 (wraps)
module hazard_ctrl #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IDRs,
    input  logic [4:0]       IDRt,
    input  logic             IDUsesRs,
    input  logic             IDUsesRt,
    input  logic             IDEXMemRead,
    input  logic             IDEXRegWrite,
    input  logic [4:0]       IDEXWriteBackDst,
    input  logic             IDEXMulDiv,
    input  logic             EXRedirect,
    output logic             PCStall,
    output logic             IFIDStall,
    output logic             IFIDFlush,
    output logic             IDEXStall,
    output logic             IDEXFlush,
    output logic             MdBusy,
    output logic [CNT_W-1:0] StallCycles
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        BUSY = 1'b1
    } state_t;

    // A mul/div stalls only when it needs more than one cycle in EX.
    localparam logic MD_ENABLED = (MULDIV_LAT > 1);
    // With a two-cycle latency the single RUN stall cycle is enough; BUSY is skipped.
    localparam logic SKIP_BUSY  = (MULDIV_LAT == 2);
    // cnt holds the number of BUSY cycles left, including the current one.
    localparam logic [3:0] CNT_LOAD = (MULDIV_LAT > 2) ? 4'(MULDIV_LAT - 2) : 4'd0;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       cnt_r;
    logic [3:0]       cnt_nxt_s;
    logic             md_done_r;
    logic             md_done_nxt_s;
    logic [CNT_W-1:0] stall_cycles_r;
    logic             lu_s;
    logic             md_s;

    // Hazard detection terms.
    always_comb begin
        lu_s = IDEXMemRead & IDEXRegWrite & (IDEXWriteBackDst != 5'd0) &
               ((IDUsesRs & (IDRs == IDEXWriteBackDst)) |
                (IDUsesRt & (IDRt == IDEXWriteBackDst)));
        md_s = (state_r == BUSY) |
               ((state_r == RUN) & IDEXMulDiv & ~md_done_r & MD_ENABLED);
    end

    // Prioritised control outputs: mul/div, then redirect, then load-use.
    // A redirect beats load-use because the ID instruction is on the wrong path.
    always_comb begin
        PCStall   = 1'b0;
        IFIDStall = 1'b0;
        IFIDFlush = 1'b0;
        IDEXStall = 1'b0;
        IDEXFlush = 1'b0;
        MdBusy    = 1'b0;
        if (rst) begin
            PCStall = 1'b0;
        end else begin
            MdBusy = (state_r == BUSY);
            if (md_s) begin
                PCStall   = 1'b1;
                IFIDStall = 1'b1;
                IDEXStall = 1'b1;
            end else if (EXRedirect) begin
                IFIDFlush = 1'b1;
                IDEXFlush = 1'b1;
            end else if (lu_s) begin
                // Hold the front end and push exactly one bubble into EX.
                PCStall   = 1'b1;
                IFIDStall = 1'b1;
                IDEXFlush = 1'b1;
            end else begin
                PCStall = 1'b0;
            end
        end
    end

    // Mul/div occupancy next-state logic.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        md_done_nxt_s = md_done_r;
        case (state_r)
            RUN: begin
                if (md_s) begin
                    if (SKIP_BUSY) begin
                        md_done_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = BUSY;
                        cnt_nxt_s   = CNT_LOAD;
                    end
                end else if (md_done_r) begin
                    // The finished mul/div leaves EX now; do not retrigger on it.
                    md_done_nxt_s = 1'b0;
                end else begin
                    md_done_nxt_s = md_done_r;
                end
            end
            BUSY: begin
                if (cnt_r > 4'd1) begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end else begin
                    state_nxt_s   = RUN;
                    cnt_nxt_s     = 4'd0;
                    md_done_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s   = RUN;
                cnt_nxt_s     = 4'd0;
                md_done_nxt_s = 1'b0;
            end
        endcase
    end

    // State, counter and done-flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= RUN;
            cnt_r     <= 4'd0;
            md_done_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            md_done_r <= md_done_nxt_s;
        end
    end

    // Stall-cycle performance counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_r <= {CNT_W{1'b0}};
        end else if (PCStall) begin
            stall_cycles_r <= stall_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign StallCycles = stall_cycles_r;

endmodule
